// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and default parameters shared by the fetch sequencer
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN} fetch_state_e;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP = 4;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run control, ROM port and decode-side signals of the fetch sequencer
interface fetch_sequencer_if;
    logic        go;
    logic        stall;
    logic        branch;
    logic [31:0] branch_addr;
    logic        mem_rdy;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [31:0] pc_rom;
    logic        read_enable_cpu;
    logic [31:0] inst_o;
    logic [31:0] pc_id;
    logic        inst_valid;
    logic        busy;
    modport master (
        input  go, stall, branch, branch_addr, mem_rdy, mem_valid, mem_rdata,
        output pc_rom, read_enable_cpu, inst_o, pc_id, inst_valid, busy
    );
    modport slave (
        output go, stall, branch, branch_addr, mem_rdy, mem_valid, mem_rdata,
        input  pc_rom, read_enable_cpu, inst_o, pc_id, inst_valid, busy
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding slot for a ROM response that decode cannot take yet
module fetch_skid_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic [31:0] data_o,
    output logic [31:0] pc_o,
    output logic        full_o
);
    logic [31:0] data_q, pc_q;
    logic        full_q;
    // capture on load, release on unload; load and unload never coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
            full_q <= 1'b1;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end
    assign data_o = data_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch from ROM with skid buffer and branch redirect
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input logic               clk,
    input logic               reset_n,
    fetch_sequencer_if.master bus
);
    fetch_state_e state_q, state_d, resume;
    logic [31:0]  pc_q, pc_d, inst_q, inst_d, pc_id_q, pc_id_d;
    logic         valid_q, valid_d;
    logic         accept, fresh, skid_load, skid_unload, skid_full;
    logic [31:0]  skid_data, skid_pc;

    assign resume      = bus.go ? FETCH : IDLE;
    assign accept      = (state_q == FETCH) && bus.mem_rdy;
    assign fresh       = (state_q == WAIT) && bus.mem_valid && !bus.branch;
    assign skid_load   = fresh && bus.stall && valid_q;
    assign skid_unload = bus.branch || ((state_q == HOLD) && !bus.stall);

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (bus.mem_rdata),
        .pc_i     (pc_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

    // next state: decode consumes the held word whenever stall is low; a branch overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q && bus.stall;
        case (state_q)
            IDLE:  state_d = (bus.go && !bus.stall) ? FETCH : IDLE;
            FETCH: state_d = accept ? WAIT : ((!bus.go || bus.stall) ? IDLE : FETCH);
            WAIT: if (bus.mem_valid) begin
                pc_d = pc_q + PC_STEP;
                if (skid_load) state_d = HOLD;
                else begin
                    inst_d  = bus.mem_rdata;
                    pc_id_d = pc_q;
                    valid_d = 1'b1;
                    state_d = resume;
                end
            end
            HOLD: if (!bus.stall) begin
                inst_d  = skid_data;
                pc_id_d = skid_pc;
                valid_d = 1'b1;
                state_d = resume;
            end
            DRAIN:   state_d = bus.mem_valid ? resume : DRAIN;
            default: state_d = IDLE;
        endcase
        if (bus.branch) begin
            pc_d    = bus.branch_addr;
            valid_d = 1'b0;
            inst_d  = inst_q;
            pc_id_d = pc_id_q;
            if (accept || (state_q == WAIT && !bus.mem_valid)) state_d = DRAIN;
            else if (state_q == WAIT || state_q == HOLD) state_d = resume;
        end
    end

    // state and registered decode-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pc_id_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    assign bus.pc_rom          = pc_q;
    assign bus.read_enable_cpu = state_q == FETCH;
    assign bus.inst_o          = inst_q;
    assign bus.pc_id           = pc_id_q;
    assign bus.inst_valid      = valid_q;
    assign bus.busy            = (state_q == WAIT) || (state_q == DRAIN) || skid_full;
endmodule
